// File: rtl/bus_copy_sequencer.sv
// Bus leader that copies Count words from a source region to a destination region,
// one read/write pair per word, with optional loop mode, stop request and read timeout.
module bus_copy_sequencer #(
  parameter logic [31:0] SrcBase    = 32'h2000_0000,
  parameter logic [31:0] DstBase    = 32'h1000_0000,
  parameter int unsigned Count      = 5,
  parameter logic [31:0] SrcStride  = 32'd4,
  parameter logic [31:0] DstStride  = 32'd0,
  parameter logic [3:0]  ByteEnable = 4'h1,
  parameter bit          AutoStart  = 1'b0,
  parameter bit          Repeat     = 1'b0,
  parameter int unsigned Timeout    = 255,
  localparam int unsigned IdxW      = $clog2(Count + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            stop_i,
  output logic [31:0]     addr_o,
  output logic            read_req_o,
  output logic            write_req_o,
  output logic [3:0]      byte_enable_o,
  output logic [31:0]     write_data_o,
  input  logic [31:0]     read_data_i,
  input  logic            read_data_valid_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [IdxW-1:0] word_index_o
);

  if (Count < 1) begin : g_bad_count
    $error("bus_copy_sequencer: Count must be at least 1");
  end

  localparam int unsigned TmoW = (Timeout > 1) ? $clog2(Timeout) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    READ_WAIT,
    WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       src_addr_q, src_addr_d;
  logic [31:0]       dst_addr_q, dst_addr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [TmoW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              first_q;

  logic last_word;
  assign last_word = (idx_q == IdxW'(Count - 1));

  // NOTE: every variable written here gets a default first, so no path can hold a value and infer a latch.
  always_comb begin
    state_d       = state_q;
    src_addr_d    = src_addr_q;
    dst_addr_d    = dst_addr_q;
    idx_d         = idx_q;
    data_d        = data_q;
    wait_cnt_d    = wait_cnt_q;
    error_d       = error_q;
    done_d        = 1'b0;
    addr_o        = '0;
    read_req_o    = 1'b0;
    write_req_o   = 1'b0;
    byte_enable_o = '0;
    write_data_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i || (AutoStart && first_q)) begin
          state_d    = READ;
          idx_d      = '0;
          src_addr_d = SrcBase;
          dst_addr_d = DstBase;
          error_d    = 1'b0;
        end
      end
      READ: begin
        addr_o     = src_addr_q;
        read_req_o = 1'b1;
        wait_cnt_d = '0;
        state_d    = READ_WAIT;
      end
      READ_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (read_data_valid_i) begin
          data_d  = read_data_i;
          state_d = WRITE;
        end else if ((Timeout != 0) && (wait_cnt_q == TmoW'(Timeout - 1))) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WRITE: begin
        addr_o        = dst_addr_q;
        write_req_o   = 1'b1;
        byte_enable_o = ByteEnable;
        write_data_o  = data_q;
        if (last_word) begin
          done_d = 1'b1;
          if (Repeat && !stop_i) begin
            state_d    = READ;
            idx_d      = '0;
            src_addr_d = SrcBase;
            dst_addr_d = DstBase;
          end else begin
            state_d = IDLE;
          end
        end else if (stop_i) begin
          state_d = IDLE;
        end else begin
          idx_d      = idx_q + 1'b1;
          src_addr_d = src_addr_q + SrcStride;
          dst_addr_d = dst_addr_q + DstStride;
          state_d    = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
      done_q     <= done_d;
      first_q    <= 1'b0;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_index_o = idx_q;

endmodule

// File: tb/tb_bus_copy_sequencer.sv
// Self-checking bench: five differently parametrised copies driven by ROM followers,
// checked every cycle against a timeline model plus literal spot checks.
module tb_bus_copy_sequencer;

  localparam int N = 5;

  typedef struct {
    logic [31:0] src, dst, ss, ds;
    int          count;
    logic [3:0]  be;
    bit          auto_s, rep;
    int          tmo, lat;  // lat 0 = follower never answers
  } cfg_t;

  function automatic cfg_t cfg_of(int i);
    cfg_t c;
    c.src = 32'h2000_0000; c.dst = 32'h1000_0000; c.ss = 32'd4; c.ds = 32'd0;
    c.count = 5; c.be = 4'h1; c.auto_s = 1'b0; c.rep = 1'b0; c.tmo = 255; c.lat = 1;
    case (i)
      1: begin c.ds = 32'd4; c.count = 3; c.be = 4'hC; c.lat = 3; end
      2: begin c.src = 32'hFFFF_FFFC; c.count = 2; c.rep = 1'b1; c.lat = 2; end
      3: begin c.tmo = 4; c.lat = 0; end
      4: begin c.auto_s = 1'b1; c.lat = 4; end
      default: ;
    endcase
    return c;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  logic        start [N];
  logic        stop [N];
  logic        rvalid [N];
  logic [31:0] rdata [N];
  logic [31:0] addr [N];
  logic [31:0] wdata [N];
  logic        rreq [N], wreq [N], busy [N], done [N], err [N];
  logic [3:0]  be [N];
  logic [2:0]  wi [N];
  logic [1:0]  wi1, wi2;

  assign wi[1] = {1'b0, wi1};
  assign wi[2] = {1'b0, wi2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_copy_sequencer u0 (
    .clk_i(clk), .reset_i(rst), .start_i(start[0]), .stop_i(stop[0]),
    .addr_o(addr[0]), .read_req_o(rreq[0]), .write_req_o(wreq[0]), .byte_enable_o(be[0]),
    .write_data_o(wdata[0]), .read_data_i(rdata[0]), .read_data_valid_i(rvalid[0]),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]), .word_index_o(wi[0]));

  bus_copy_sequencer #(.Count(3), .DstStride(32'd4), .ByteEnable(4'hC)) u1 (
    .clk_i(clk), .reset_i(rst), .start_i(start[1]), .stop_i(stop[1]),
    .addr_o(addr[1]), .read_req_o(rreq[1]), .write_req_o(wreq[1]), .byte_enable_o(be[1]),
    .write_data_o(wdata[1]), .read_data_i(rdata[1]), .read_data_valid_i(rvalid[1]),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]), .word_index_o(wi1));

  bus_copy_sequencer #(.SrcBase(32'hFFFF_FFFC), .Count(2), .Repeat(1'b1)) u2 (
    .clk_i(clk), .reset_i(rst), .start_i(start[2]), .stop_i(stop[2]),
    .addr_o(addr[2]), .read_req_o(rreq[2]), .write_req_o(wreq[2]), .byte_enable_o(be[2]),
    .write_data_o(wdata[2]), .read_data_i(rdata[2]), .read_data_valid_i(rvalid[2]),
    .busy_o(busy[2]), .done_o(done[2]), .error_o(err[2]), .word_index_o(wi2));

  bus_copy_sequencer #(.Timeout(4)) u3 (
    .clk_i(clk), .reset_i(rst), .start_i(start[3]), .stop_i(stop[3]),
    .addr_o(addr[3]), .read_req_o(rreq[3]), .write_req_o(wreq[3]), .byte_enable_o(be[3]),
    .write_data_o(wdata[3]), .read_data_i(rdata[3]), .read_data_valid_i(rvalid[3]),
    .busy_o(busy[3]), .done_o(done[3]), .error_o(err[3]), .word_index_o(wi[3]));

  bus_copy_sequencer #(.AutoStart(1'b1)) u4 (
    .clk_i(clk), .reset_i(rst), .start_i(start[4]), .stop_i(stop[4]),
    .addr_o(addr[4]), .read_req_o(rreq[4]), .write_req_o(wreq[4]), .byte_enable_o(be[4]),
    .write_data_o(wdata[4]), .read_data_i(rdata[4]), .read_data_valid_i(rvalid[4]),
    .busy_o(busy[4]), .done_o(done[4]), .error_o(err[4]), .word_index_o(wi[4]));

  // ROM follower: word at SrcBase + 4*n holds 5 + n, answered lat cycles after the request.
  // Not reset, so a read in flight across reset still answers afterwards.
  initial begin
    int          due [N];
    logic [31:0] pend [N];
    cfg_t        c;
    for (int i = 0; i < N; i++) begin
      rvalid[i] = 1'b0; rdata[i] = '0; due[i] = -1; pend[i] = '0;
    end
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        c = cfg_of(i);
        rvalid[i] = (due[i] == cyc);
        rdata[i]  = rvalid[i] ? pend[i] : 32'hDEAD_BEEF;
        if (rreq[i] && c.lat != 0) begin
          due[i]  = cyc + c.lat;
          pend[i] = 32'd5 + ((addr[i] - c.src) >> 2);
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef enum int {EV_RD, EV_WR, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    int          inst;
    ev_kind_e    kind;
    int          cyc;
    logic [31:0] addr, data;
  } ev_t;
  ev_t evq[$];

  function automatic int ev_count(int inst, ev_kind_e k, int from);
    int cnt = 0;
    foreach (evq[j]) if (evq[j].inst == inst && evq[j].kind == k && evq[j].cyc >= from) cnt++;
    return cnt;
  endfunction

  function automatic ev_t ev_nth(int inst, ev_kind_e k, int from, int n);
    ev_t r;
    int  seen = 0;
    r.inst = inst; r.kind = k; r.cyc = -1; r.addr = '0; r.data = '0;
    foreach (evq[j]) begin
      if (evq[j].inst == inst && evq[j].kind == k && evq[j].cyc >= from) begin
        if (seen == n) return evq[j];
        seen++;
      end
    end
    return r;
  endfunction

  typedef struct packed {
    logic        busy, rreq, wreq, done, err;
    logic [3:0]  be;
    logic [2:0]  wi;
    logic [31:0] addr, wd;
  } obs_t;

  // Timeline model: a pass starting at cycle s is a sequence of (lat+2)-cycle word slots:
  // read in slot cycle 0, write in the last slot cycle.
  bit m_act [N]  = '{default: 1'b0};
  int m_s [N]    = '{default: 0};
  bit m_err [N]  = '{default: 1'b0};
  bit m_dn [N]   = '{default: 1'b0};
  bit m_apend [N] = '{default: 1'b0};
  bit prev_err [N] = '{default: 1'b0};

  always @(negedge clk) begin
    cfg_t c;
    obs_t e, o;
    int   k, n, ph, wl;
    bit   chk_wi;
    ev_t  ev;
    for (int i = 0; i < N; i++) begin
      c = cfg_of(i);
      e = '0;
      chk_wi = 1'b0;
      if (rst) begin
        m_act[i] = 1'b0; m_err[i] = 1'b0; m_dn[i] = 1'b0; m_apend[i] = c.auto_s; chk_wi = 1'b1;
      end else begin
        e.done = m_dn[i]; m_dn[i] = 1'b0;
        e.err  = m_err[i];
        if (m_act[i]) begin
          k = cyc - m_s[i]; e.busy = 1'b1; chk_wi = 1'b1;
          if (c.lat == 0) begin
            if (k == 0) begin e.rreq = 1'b1; e.addr = c.src; end
            if (k == c.tmo) begin m_act[i] = 1'b0; m_err[i] = 1'b1; end
          end else begin
            wl = c.lat + 2; n = (k / wl) % c.count; ph = k % wl; e.wi = 3'(n);
            if (ph == 0) begin
              e.rreq = 1'b1; e.addr = c.src + 32'(n) * c.ss;
            end else if (ph == wl - 1) begin
              e.wreq = 1'b1; e.addr = c.dst + 32'(n) * c.ds; e.be = c.be; e.wd = 32'(5 + n);
              if (n == c.count - 1) begin
                m_dn[i] = 1'b1;
                if (!c.rep || stop[i]) m_act[i] = 1'b0;
              end else if (stop[i]) begin
                m_act[i] = 1'b0;
              end
            end
          end
        end else if (start[i] || m_apend[i]) begin
          m_act[i] = 1'b1; m_s[i] = cyc + 1; m_err[i] = 1'b0;
        end
        m_apend[i] = 1'b0;
      end
      o = {busy[i], rreq[i], wreq[i], done[i], err[i], be[i], chk_wi ? wi[i] : 3'd0, addr[i], wdata[i]};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL cycle_model u%0d cyc %0d: got busy/rd/wr/done/err %b%b%b%b%b be %h idx %0d addr %h wdata %h; expected %b%b%b%b%b be %h idx %0d addr %h wdata %h",
                 i, cyc, o.busy, o.rreq, o.wreq, o.done, o.err, o.be, o.wi, o.addr, o.wd,
                 e.busy, e.rreq, e.wreq, e.done, e.err, e.be, e.wi, e.addr, e.wd);
      end
      ev.inst = i; ev.cyc = cyc; ev.addr = addr[i]; ev.data = wdata[i];
      if (rreq[i] === 1'b1) begin ev.kind = EV_RD; evq.push_back(ev); end
      if (wreq[i] === 1'b1) begin ev.kind = EV_WR; evq.push_back(ev); end
      if (done[i] === 1'b1) begin ev.kind = EV_DONE; evq.push_back(ev); end
      if (err[i] === 1'b1 && !prev_err[i]) begin ev.kind = EV_ERR; evq.push_back(ev); end
      prev_err[i] = (err[i] === 1'b1);
    end
  end

  task automatic pulse_start(input int i, output int x);
    @(posedge clk); #1;
    start[i] = 1'b1;
    x = cyc;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0, t0, x, x2;
    ev_t ev, ev_prev;
    for (int i = 0; i < N; i++) begin start[i] = 1'b0; stop[i] = 1'b0; end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy u4", 32'(busy[4]), 32'd0);
    check("reset addr u0", addr[0], 32'd0);
    check("reset rreq u4", 32'(rreq[4]), 32'd0);
    check("reset word_index u0", 32'(wi[0]), 32'd0);
    rst = 1'b0;
    r0 = cyc;

    // AutoStart pass (L=4) interrupted by reset during word 2 READ_WAIT; the read answers after release
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    check("autostart first read cycle", 32'(ev_nth(4, EV_RD, r0, 0).cyc), 32'(r0 + 1));
    check("writes before reset", 32'(ev_count(4, EV_WR, r0)), 32'd2);
    check("release cycle busy", 32'(busy[4]), 32'd0);
    check("release cycle write_req", 32'(wreq[4]), 32'd0);
    repeat (36) @(posedge clk);
    #1;
    ev = ev_nth(4, EV_RD, t0, 0);
    check("restart read cycle", 32'(ev.cyc), 32'(t0 + 1));
    check("restart read addr", ev.addr, 32'h2000_0000);
    check("restart first write data", ev_nth(4, EV_WR, t0, 0).data, 32'd5);
    check("restart write count", 32'(ev_count(4, EV_WR, t0)), 32'd5);
    check("restart done count", 32'(ev_count(4, EV_DONE, t0)), 32'd1);

    // Defaults: 5 words, L=1; a start during the final WRITE is ignored
    pulse_start(0, x);
    repeat (14) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      ev = ev_nth(0, EV_WR, x, j);
      check($sformatf("default write %0d data", j), ev.data, 32'(5 + j));
      check($sformatf("default write %0d addr", j), ev.addr, 32'h1000_0000);
    end
    check("default done delay", 32'(ev_nth(0, EV_DONE, x, 0).cyc - (x + 1)), 32'd15);
    check("default done count", 32'(ev_count(0, EV_DONE, x)), 32'd1);
    check("default read count", 32'(ev_count(0, EV_RD, x)), 32'd5);
    check("default busy after", 32'(busy[0]), 32'd0);

    // DstStride=4, Count=3, L=3
    pulse_start(1, x);
    repeat (20) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      ev = ev_nth(1, EV_WR, x, j);
      check($sformatf("stride write %0d addr", j), ev.addr, 32'h1000_0000 + 32'(4 * j));
      check($sformatf("stride read %0d addr", j), ev_nth(1, EV_RD, x, j).addr, 32'h2000_0000 + 32'(4 * j));
      if (j > 0) begin
        ev_prev = ev_nth(1, EV_WR, x, j - 1);
        check($sformatf("stride spacing %0d", j), 32'(ev.cyc - ev_prev.cyc), 32'd5);
      end
    end

    // Repeat=1, Count=2, SrcBase wraps; stop during second word of second pass
    pulse_start(2, x);
    repeat (13) @(posedge clk);
    #1 stop[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1 stop[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("wrap second read addr", ev_nth(2, EV_RD, x, 1).addr, 32'h0000_0000);
    check("stop read count", 32'(ev_count(2, EV_RD, x)), 32'd4);
    check("stop write count", 32'(ev_count(2, EV_WR, x)), 32'd4);
    check("stop last write data", ev_nth(2, EV_WR, x, 3).data, 32'd6);
    check("stop done count", 32'(ev_count(2, EV_DONE, x)), 32'd2);
    check("stop busy after", 32'(busy[2]), 32'd0);

    // Timeout=4 with a silent follower
    pulse_start(3, x);
    repeat (8) @(posedge clk);
    #1;
    check("timeout error delay", 32'(ev_nth(3, EV_ERR, x, 0).cyc - (x + 2)), 32'd4);
    check("timeout no write", 32'(ev_count(3, EV_WR, x)), 32'd0);
    check("timeout no done", 32'(ev_count(3, EV_DONE, x)), 32'd0);
    check("timeout error sticky", 32'(err[3]), 32'd1);
    pulse_start(3, x2);
    check("restart clears error", 32'(err[3]), 32'd0);
    check("restart busy", 32'(busy[3]), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("second timeout", 32'(ev_count(3, EV_ERR, x2)), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
